// File: rtl/y_muldiv_pkg.sv
// rtl/y_muldiv_pkg.sv - op encodings and FSM state type shared by the mul/div unit and ID decode
package y_muldiv_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/y_muldiv_step.sv
// rtl/y_muldiv_step.sv - one shift-add multiply or restoring divide iteration on the 2*WIDTH accumulator
module y_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic                 op_bit,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial_hi, product_lo}; add then shift right, product bits fill from the top.
    // Divide:   acc = {remainder, quotient}; shift in the next dividend bit, subtract if it fits.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (op_bit ? {1'b0, opnd} : '0);
        trial    = {acc[2*WIDTH-1:WIDTH], op_bit};
        diff     = trial[WIDTH-1:0] - opnd;
        acc_next = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (trial >= {1'b0, opnd}) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/y_muldiv.sv
// rtl/y_muldiv.sv - multi-cycle unsigned MUL/MULHU/DIVU/REMU unit with start/busy/done handshake
module y_muldiv
    import y_muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             ex
);

    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic               ex_q, ex_d;

    logic               accept;
    logic               last;
    logic               is_div;
    logic               op_bit;
    logic [CW-1:0]      a_idx;
    logic [WIDTH-1:0]   res;

    assign accept = start && (state_q != RUN);
    assign last   = (state_q == RUN) && (cnt_q == CW'(WIDTH - 1));
    assign is_div = op_q[1];
    assign a_idx  = CW'(WIDTH - 1) - cnt_q;
    // Multiplier bits are consumed LSB first, dividend bits MSB first.
    assign op_bit = is_div ? a_q[a_idx] : b_q[cnt_q];

    y_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .op_bit   (op_bit),
        .acc      (acc_q),
        .opnd     (is_div ? b_q : a_q),
        .acc_next (acc_step)
    );

    // op[0] picks the upper accumulator half: MULHU high product, REMU remainder.
    assign res = op_q[0] ? acc_step[2*WIDTH-1:WIDTH] : acc_step[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        z_d   = z_q;
        ex_d  = ex_q;
        if (accept) begin
            cnt_d = '0;
            acc_d = '0;
            a_d   = a;
            b_d   = b;
            op_d  = op;
        end else if (state_q == RUN) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = acc_step;
            if (last) begin
                z_d  = res;
                ex_d = is_div && (b_q == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            z_q   <= '0;
            ex_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            z_q   <= z_d;
            ex_q  <= ex_d;
        end
    end

    assign z  = z_q;
    assign ex = ex_q;

endmodule

// File: tb/tb_y_muldiv.sv
// tb/tb_y_muldiv.sv - directed WIDTH=32 and randomized WIDTH=8 checks of y_muldiv against an arithmetic model
module tb_y_muldiv;
    import y_muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start32 = 1'b0;
    logic [1:0]  op32 = '0;
    logic [31:0] a32 = '0, b32 = '0, z32;
    logic        busy32, done32, ex32;

    logic        start8 = 1'b0;
    logic [1:0]  op8 = '0;
    logic [7:0]  a8 = '0, b8 = '0, z8;
    logic        busy8, done8, ex8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    y_muldiv #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .z(z32), .ex(ex32)
    );

    y_muldiv #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .z(z8), .ex(ex8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] model8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        p = a * b;
        case (op)
            OP_MUL:   return {1'b0, p[7:0]};
            OP_MULHU: return {1'b0, p[15:8]};
            OP_DIVU:  return (b == 0) ? {1'b1, 8'hFF} : {1'b0, 8'(a / b)};
            default:  return (b == 0) ? {1'b1, a} : {1'b0, 8'(a % b)};
        endcase
    endfunction

    task automatic op32_run(input string tag, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ez, input logic eex);
        int n;
        bit busy_ok;
        @(negedge clk);
        start32 = 1'b1; op32 = op; a32 = a; b32 = b;
        @(posedge clk); #1;
        start32 = 1'b0; a32 = $urandom; b32 = $urandom;
        n = 0; busy_ok = 1'b1;
        while (!done32 && n < 100) begin
            if (!busy32) busy_ok = 1'b0;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_lat"}, n, 32);
        check({tag, "_busy"}, busy_ok, 1);
        check({tag, "_busy_at_done"}, busy32, 0);
        check({tag, "_z"}, z32, ez);
        check({tag, "_ex"}, ex32, eex);
    endtask

    task automatic op8_run(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        logic [8:0] exp;
        exp = model8(op, a, b);
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        n = 0;
        while (!done8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("rnd_lat", n, 8);
        check($sformatf("rnd_z op%0d %0h,%0h", op, a, b), z8, exp[7:0]);
        check($sformatf("rnd_ex op%0d %0h,%0h", op, a, b), ex8, exp[8]);
    endtask

    initial begin
        int n;
        int dones;
        logic [1:0] rop;
        logic [7:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy32, 0);
        check("rst_done", done32, 0);
        check("rst_z", z32, 0);
        check("rst_ex", ex32, 0);
        @(negedge clk) rst_n = 1'b1;

        op32_run("mul7x6", OP_MUL, 32'd7, 32'd6, 32'd42, 1'b0);
        op32_run("mulhu_ff", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
        op32_run("mul_ff", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        op32_run("divu100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);
        op32_run("remu100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0);
        op32_run("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1);
        op32_run("remu_by0", OP_REMU, 32'd5, 32'd0, 32'd5, 1'b1);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        start32 = 1'b1; op32 = OP_MUL; a32 = 32'd7; b32 = 32'd6;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        start32 = 1'b1; op32 = OP_DIVU; a32 = 32'd1000; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        dones = 0; n = 0;
        repeat (45) begin
            if (done32) begin
                dones++;
                if (dones == 1) check("midrun_z", z32, 42);
            end
            @(posedge clk); #1;
        end
        check("midrun_dones", dones, 1);
        check("midrun_idle", busy32, 0);

        // back-to-back: MUL 3*3 then DIVU 9/3 requested during the done cycle
        @(negedge clk);
        start32 = 1'b1; op32 = OP_MUL; a32 = 32'd3; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        n = 0;
        while (!done32 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_lat1", n, 32);
        check("b2b_z1", z32, 9);
        start32 = 1'b1; op32 = OP_DIVU; a32 = 32'd9; b32 = 32'd3;
        @(posedge clk); #1;
        start32 = 1'b0;
        check("b2b_busy", busy32, 1);
        check("b2b_done_fall", done32, 0);
        n = 1;
        while (!done32 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_gap", n, 33);
        check("b2b_z2", z32, 3);

        // reset at cycle 10 of a DIVU aborts it
        @(negedge clk);
        start32 = 1'b1; op32 = OP_DIVU; a32 = 32'd100; b32 = 32'd7;
        @(posedge clk); #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy32, 0);
        check("abort_done", done32, 0);
        check("abort_z", z32, 0);
        check("abort_ex", ex32, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 || busy32) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_z_hold", z32, 0);

        // WIDTH=8 random regression
        for (int i = 0; i < 60; i++) begin
            rop = 2'($urandom);
            ra  = 8'($urandom);
            rb  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            op8_run(rop, ra, rb);
        end
        op8_run(OP_MULHU, 8'hFF, 8'hFF);
        op8_run(OP_DIVU, 8'hFF, 8'd1);
        op8_run(OP_REMU, 8'd0, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
